// File: rtl/cook_controller.sv
// rtl/cook_controller.sv - keypad-programmed BCD cooking timer with power-level duty cycling
module cook_controller #(
    parameter int TICK_DIV     = 50_000_000,
    parameter int MIN_DIGITS   = 1,
    parameter int POWER_LEVELS = 10
) (
    input  logic                    clk,
    input  logic                    resetn,
    input  logic [9:0]              keypad,
    input  logic                    power_key,
    input  logic                    startn,
    input  logic                    stopn,
    input  logic                    clearn,
    input  logic                    door_closed,
    output logic [3:0]              seconds_ones,
    output logic [3:0]              seconds_tens,
    output logic [4*MIN_DIGITS-1:0] minutes,
    output logic [3:0]              power_level,
    output logic                    mag_on,
    output logic                    cooking,
    output logic                    done
);

    localparam int DW = 4 * (MIN_DIGITS + 2);
    localparam int PW = $clog2(TICK_DIV);
    localparam logic [PW-1:0] PRESC_MAX = PW'(TICK_DIV - 1);
    localparam logic [3:0]    PMAX      = 4'(POWER_LEVELS);
    localparam logic [3:0]    DUTY_MAX  = 4'(POWER_LEVELS - 1);

    typedef enum logic [2:0] {IDLE, ENTRY, COOK, PAUSE, DONE} state_t;

    state_t          state, state_n;
    logic [DW-1:0]   digits, digits_n;
    logic [3:0]      power_n;
    logic [PW-1:0]   presc, presc_n;
    logic [3:0]      duty, duty_n;

    logic [9:0]      keypad_q;
    logic            power_q, start_q, stop_q, clear_q;
    logic            key_ev, key_one, power_ev, start_ev, stop_ev, clear_ev, tick;
    logic [3:0]      key_digit;
    logic [DW-1:0]   digits_dec;

    // Whole display is one borrow chain; the seconds-tens digit wraps to 5, all others to 9.
    function automatic logic [DW-1:0] bcd_dec(input logic [DW-1:0] d);
        logic [DW-1:0] r;
        logic          borrow;
        r      = d;
        borrow = 1'b1;
        for (int i = 0; i < MIN_DIGITS + 2; i++) begin
            if (borrow) begin
                if (d[4*i +: 4] == 4'd0) begin
                    r[4*i +: 4] = (i == 1) ? 4'd5 : 4'd9;
                end else begin
                    r[4*i +: 4] = d[4*i +: 4] - 4'd1;
                    borrow      = 1'b0;
                end
            end
        end
        return r;
    endfunction

    assign key_ev   = |(keypad & ~keypad_q);
    assign key_one  = $onehot(keypad);
    assign power_ev = power_key & ~power_q;
    assign start_ev = ~startn & start_q;
    assign stop_ev  = ~stopn & stop_q;
    assign clear_ev = ~clearn & clear_q;
    assign tick     = (state == COOK) && (presc == PRESC_MAX);
    assign digits_dec = bcd_dec(digits);

    always_comb begin
        key_digit = 4'd0;
        for (int i = 0; i < 10; i++) begin
            if (keypad[i]) key_digit = 4'(i);
        end
    end

    always_comb begin
        state_n  = state;
        digits_n = digits;
        power_n  = power_level;
        presc_n  = presc;
        duty_n   = duty;

        if (power_ev && (state == IDLE || state == ENTRY || state == PAUSE))
            power_n = (power_level == 4'd1) ? PMAX : power_level - 4'd1;

        if (state == COOK)
            presc_n = tick ? '0 : presc + 1'b1;

        // Events consumed in priority order; a lower one is dropped when a higher one fires.
        if (!door_closed && state == COOK) begin
            state_n = PAUSE;
        end else if (!door_closed && state == DONE) begin
            state_n = IDLE;
        end else if (clear_ev) begin
            state_n  = IDLE;
            digits_n = '0;
        end else if (stop_ev && state != DONE) begin
            if (state == COOK) begin
                state_n = PAUSE;
            end else if (state == PAUSE) begin
                state_n  = IDLE;
                digits_n = '0;
            end
        end else if (start_ev && door_closed && digits != '0 &&
                     (state == ENTRY || state == PAUSE)) begin
            state_n = COOK;
            presc_n = '0;
            duty_n  = '0;
        end else if (key_ev && state == DONE) begin
            state_n  = IDLE;
            digits_n = '0;
        end else if (key_ev && key_one && (state == IDLE || state == ENTRY)) begin
            state_n  = ENTRY;
            digits_n = {digits[DW-5:0], key_digit};
        end else if (tick) begin
            digits_n = digits_dec;
            duty_n   = (duty == DUTY_MAX) ? 4'd0 : duty + 4'd1;
            if (digits_dec == '0) state_n = DONE;
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state       <= IDLE;
            digits      <= '0;
            power_level <= PMAX;
            presc       <= '0;
            duty        <= '0;
            keypad_q    <= '0;
            power_q     <= 1'b0;
            start_q     <= 1'b1;
            stop_q      <= 1'b1;
            clear_q     <= 1'b1;
            mag_on      <= 1'b0;
            cooking     <= 1'b0;
            done        <= 1'b0;
        end else begin
            state       <= state_n;
            digits      <= digits_n;
            power_level <= power_n;
            presc       <= presc_n;
            duty        <= duty_n;
            keypad_q    <= keypad;
            power_q     <= power_key;
            start_q     <= startn;
            stop_q      <= stopn;
            clear_q     <= clearn;
            mag_on      <= (state_n == COOK) && (duty_n < power_n);
            cooking     <= (state_n == COOK);
            done        <= (state_n == DONE);
        end
    end

    assign seconds_ones = digits[3:0];
    assign seconds_tens = digits[7:4];
    assign minutes      = digits[DW-1:8];

endmodule

// File: tb/tb_cook_controller.sv
// tb/tb_cook_controller.sv - table, directed and randomized checks of cook_controller against a value-level model
module tb_cook_controller;

    localparam int TD = 4;
    localparam int MD = 1;
    localparam int PL = 10;
    localparam int MW = 4 * MD;
    localparam int OW = 15 + MW;

    logic          clk = 1'b0;
    logic          resetn;
    logic [9:0]    keypad;
    logic          power_key, startn, stopn, clearn, door_closed;
    logic [3:0]    seconds_ones, seconds_tens, power_level;
    logic [MW-1:0] minutes;
    logic          mag_on, cooking, done;

    cook_controller #(.TICK_DIV(TD), .MIN_DIGITS(MD), .POWER_LEVELS(PL)) dut (
        .clk(clk), .resetn(resetn), .keypad(keypad), .power_key(power_key),
        .startn(startn), .stopn(stopn), .clearn(clearn), .door_closed(door_closed),
        .seconds_ones(seconds_ones), .seconds_tens(seconds_tens), .minutes(minutes),
        .power_level(power_level), .mag_on(mag_on), .cooking(cooking), .done(done)
    );

    always #5 clk = ~clk;

    int vectors = 0;
    int miscompares = 0;

    // Model keeps the display as a plain decimal number mmss.
    localparam int M_IDLE = 0, M_ENTRY = 1, M_COOK = 2, M_PAUSE = 3, M_DONE = 4;
    int         m_mode, m_val, m_pow, m_cyc, m_ticks;
    logic [9:0] p_kp;
    logic       p_pk, p_st, p_sp, p_cl;

    task automatic model_reset();
        m_mode = M_IDLE; m_val = 0; m_pow = PL; m_cyc = 0; m_ticks = 0;
        p_kp = '0; p_pk = 1'b0; p_st = 1'b1; p_sp = 1'b1; p_cl = 1'b1;
    endtask

    task automatic model_step();
        bit kev, one, pev, sev, spv, cev, tk;
        int digit;
        kev = (keypad & ~p_kp) != 0;
        one = $countones(keypad) == 1;
        digit = 0;
        for (int i = 0; i < 10; i++) if (keypad[i]) digit = i;
        pev = power_key && !p_pk;
        sev = !startn && p_st;
        spv = !stopn && p_sp;
        cev = !clearn && p_cl;
        tk  = (m_mode == M_COOK) && (m_cyc % TD == TD - 1);
        if (m_mode == M_COOK) m_cyc++;
        if (pev && (m_mode == M_IDLE || m_mode == M_ENTRY || m_mode == M_PAUSE))
            m_pow = (m_pow == 1) ? PL : m_pow - 1;
        if (!door_closed && m_mode == M_COOK) m_mode = M_PAUSE;
        else if (!door_closed && m_mode == M_DONE) m_mode = M_IDLE;
        else if (cev) begin m_mode = M_IDLE; m_val = 0; end
        else if (spv && m_mode != M_DONE) begin
            if (m_mode == M_COOK) m_mode = M_PAUSE;
            else if (m_mode == M_PAUSE) begin m_mode = M_IDLE; m_val = 0; end
        end
        else if (sev && door_closed && m_val != 0 && (m_mode == M_ENTRY || m_mode == M_PAUSE)) begin
            m_mode = M_COOK; m_cyc = 0; m_ticks = 0;
        end
        else if (kev && m_mode == M_DONE) begin m_mode = M_IDLE; m_val = 0; end
        else if (kev && one && (m_mode == M_IDLE || m_mode == M_ENTRY)) begin
            m_val = (m_val * 10 + digit) % (10 ** (MD + 2));
            m_mode = M_ENTRY;
        end
        else if (tk) begin
            m_val = (m_val % 100 == 0) ? m_val - 41 : m_val - 1;
            m_ticks++;
            if (m_val == 0) m_mode = M_DONE;
        end
        p_kp = keypad; p_pk = power_key; p_st = startn; p_sp = stopn; p_cl = clearn;
    endtask

    task automatic check_model(string name);
        logic [OW-1:0] act, exp;
        logic e_mag;
        e_mag = (m_mode == M_COOK) && ((m_ticks % PL) < m_pow);
        act = {seconds_ones, seconds_tens, minutes, power_level, mag_on, cooking, done};
        exp = {4'(m_val % 10), 4'((m_val / 10) % 10), MW'(m_val / 100), 4'(m_pow),
               e_mag, m_mode == M_COOK, m_mode == M_DONE};
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic check(string name, logic [31:0] act, logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic step(string name);
        model_step();
        @(posedge clk);
        #1;
        check_model(name);
    endtask

    task automatic cycles(int n, string name);
        repeat (n) step(name);
    endtask

    task automatic key(int d);
        keypad = 10'(1) << d; step("key");
        keypad = '0;          step("key_rel");
    endtask

    task automatic press_start();
        startn = 1'b0; step("start");
        startn = 1'b1;
    endtask

    typedef struct packed {
        logic [9:0] kp;
        logic       pk, st, sp, cl, dr;
        logic [3:0] ones, tens, mins, pwr;
        logic       mag, cook, dn;
    } vec_t;

    function automatic vec_t mk(int kp, int st, int sp, int cl, int o, int t, int m, int mg, int ck);
        vec_t v;
        v.kp = 10'(kp); v.pk = 1'b0; v.st = 1'(st); v.sp = 1'(sp); v.cl = 1'(cl); v.dr = 1'b1;
        v.ones = 4'(o); v.tens = 4'(t); v.mins = 4'(m); v.pwr = 4'(PL);
        v.mag = 1'(mg); v.cook = 1'(ck); v.dn = 1'b0;
        return v;
    endfunction

    vec_t tbl[18];

    initial begin
        tbl[0]  = mk(0,      1, 1, 1, 0, 0, 0, 0, 0);
        tbl[1]  = mk(1 << 1, 1, 1, 1, 1, 0, 0, 0, 0);
        tbl[2]  = mk(0,      1, 1, 1, 1, 0, 0, 0, 0);
        tbl[3]  = mk(1 << 3, 1, 1, 1, 3, 1, 0, 0, 0);
        tbl[4]  = mk(0,      1, 1, 1, 3, 1, 0, 0, 0);
        tbl[5]  = mk(1 << 0, 1, 1, 1, 0, 3, 1, 0, 0);
        tbl[6]  = mk(0,      1, 1, 1, 0, 3, 1, 0, 0);
        tbl[7]  = mk(3,      1, 1, 1, 0, 3, 1, 0, 0);
        tbl[8]  = mk(0,      1, 1, 1, 0, 3, 1, 0, 0);
        tbl[9]  = mk(0,      0, 1, 1, 0, 3, 1, 1, 1);
        tbl[10] = mk(0,      1, 1, 1, 0, 3, 1, 1, 1);
        tbl[11] = mk(0,      1, 1, 1, 0, 3, 1, 1, 1);
        tbl[12] = mk(0,      1, 1, 1, 0, 3, 1, 1, 1);
        tbl[13] = mk(0,      1, 1, 1, 9, 2, 1, 1, 1);
        tbl[14] = mk(1 << 7, 1, 1, 1, 9, 2, 1, 1, 1);
        tbl[15] = mk(0,      1, 1, 1, 9, 2, 1, 1, 1);
        tbl[16] = mk(0,      1, 0, 0, 0, 0, 0, 0, 0);
        tbl[17] = mk(0,      1, 1, 1, 0, 0, 0, 0, 0);

        resetn = 1'b0; keypad = '0; power_key = 1'b0;
        startn = 1'b1; stopn = 1'b1; clearn = 1'b1; door_closed = 1'b1;
        model_reset();
        repeat (2) @(negedge clk);
        check_model("reset");
        check("reset_power", power_level, PL);
        resetn = 1'b1;

        for (int i = 0; i < 18; i++) begin
            keypad = tbl[i].kp; power_key = tbl[i].pk; startn = tbl[i].st;
            stopn = tbl[i].sp; clearn = tbl[i].cl; door_closed = tbl[i].dr;
            step("table_model");
            check($sformatf("table_row%0d", i),
                  {seconds_ones, seconds_tens, minutes, power_level, mag_on, cooking, done},
                  {tbl[i].ones, tbl[i].tens, tbl[i].mins, tbl[i].pwr, tbl[i].mag, tbl[i].cook, tbl[i].dn});
        end

        // Power level 3 over a 5 s cook: on for 3 ticks, off for 2, then DONE.
        repeat (7) begin
            power_key = 1'b1; step("pwr");
            power_key = 1'b0; step("pwr_rel");
        end
        check("power_after7", power_level, 3);
        key(5);
        press_start();
        check("duty_start_mag", mag_on, 1);
        for (int k = 1; k <= 20; k++) begin
            step("duty");
            if (k == 11) check("duty_k11_mag", mag_on, 1);
            if (k == 12) check("duty_k12_mag_ones", {mag_on, seconds_ones}, {1'b0, 4'd2});
            if (k == 19) check("duty_k19_done", {done, seconds_ones}, {1'b0, 4'd1});
            if (k == 20) check("duty_k20_done", {done, mag_on, cooking, seconds_ones}, {3'b100, 4'd0});
        end
        press_start();
        step("done_start");
        check("done_start_ignored", done, 1);
        keypad = 10'(1) << 2; step("done_key");
        check("done_key_exit", {done, seconds_ones}, {1'b0, 4'd0});
        keypad = '0; step("done_key_rel");

        // Door opens on a tick cycle: tick dropped, start ignored while open.
        key(1); key(0);
        press_start();
        cycles(8, "door_run");
        check("door_run_0_08", {seconds_tens, seconds_ones}, {4'd0, 4'd8});
        cycles(3, "door_pre");
        door_closed = 1'b0; step("door_open");
        check("door_pause", {cooking, mag_on, seconds_ones}, {2'b00, 4'd8});
        press_start();
        step("door_open_start");
        check("door_start_ignored", cooking, 0);
        cycles(6, "door_frozen");
        check("door_frozen", seconds_ones, 8);
        door_closed = 1'b1;
        press_start();
        check("door_resume", cooking, 1);
        cycles(3, "resume");
        check("resume_hold", seconds_ones, 8);
        cycles(1, "resume_tick");
        check("resume_0_07", seconds_ones, 7);

        // Stop pauses, second stop clears, start on zero time ignored.
        stopn = 1'b0; step("stop1");
        check("stop_pause", {cooking, seconds_ones}, {1'b0, 4'd7});
        stopn = 1'b1; step("stop_rel");
        stopn = 1'b0; step("stop2");
        check("stop_clear", {seconds_tens, seconds_ones, minutes}, 12'd0);
        stopn = 1'b1; step("stop_rel2");
        press_start();
        step("zero_start");
        check("zero_start_ignored", cooking, 0);

        // Start and stop together in ENTRY, then clear while cooking.
        key(4);
        startn = 1'b0; stopn = 1'b0; step("start_stop");
        check("start_stop_entry", {cooking, seconds_ones}, {1'b0, 4'd4});
        startn = 1'b1; stopn = 1'b1; step("ss_rel");
        press_start();
        check("entry_kept_start", cooking, 1);
        clearn = 1'b0; step("clear_cook");
        check("clear_cook", {cooking, seconds_ones}, {1'b0, 4'd0});
        clearn = 1'b1; step("clear_rel");

        key(1); key(2); key(3); key(4);
        check("entry_2_34", {minutes, seconds_tens, seconds_ones}, {4'd2, 4'd3, 4'd4});

        clearn = 1'b0; step("clear"); clearn = 1'b1; step("clear_rel");
        key(9); key(0);
        press_start();
        cycles(4, "ninety");
        check("ninety_0_89", {minutes, seconds_tens, seconds_ones}, {4'd0, 4'd8, 4'd9});

        // Asynchronous reset in the middle of cooking.
        resetn = 1'b0;
        #1;
        check("async_reset_outs",
              {seconds_ones, seconds_tens, minutes, mag_on, cooking, done}, '0);
        check("async_reset_power", power_level, PL);
        model_reset();
        @(posedge clk); #1;
        resetn = 1'b1;

        for (int n = 0; n < 4000; n++) begin
            int r;
            r = $urandom_range(0, 99);
            if (r < 8)       keypad = 10'(1) << $urandom_range(0, 9);
            else if (r < 10) keypad = (10'(1) << $urandom_range(0, 4)) | (10'(1) << $urandom_range(5, 9));
            else             keypad = '0;
            power_key = ($urandom_range(0, 19) == 0);
            startn    = !($urandom_range(0, 7) == 0);
            stopn     = !($urandom_range(0, 79) == 0);
            clearn    = !($urandom_range(0, 199) == 0);
            if ($urandom_range(0, 99) == 0) door_closed = !door_closed;
            step("random");
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
